// File: rtl/reorder_buffer.sv
// reorder_buffer: 16-entry circular reorder buffer. Allocates one entry per
// dispatched instruction, captures CDB results, answers operand-forwarding
// queries combinationally and retires at most one instruction per cycle in
// program order. A committed branch that resolves against its prediction
// flushes the whole buffer and redirects fetch.
module reorder_buffer #(
    parameter int RoB_WIDTH    = 4,
    parameter int EX_REG_WIDTH = 6
) (
    input  logic                    Sys_clk,
    input  logic                    Sys_rst,
    input  logic                    Sys_rdy,
    // dispatcher side
    input  logic                    DPRoB_en,
    input  logic [1:0]              DPRoB_type,
    input  logic [EX_REG_WIDTH-1:0] DPRoB_rd,
    input  logic                    DPRoB_pred_jump,
    input  logic [RoB_WIDTH-1:0]    DPRoB_Qj,
    input  logic [RoB_WIDTH-1:0]    DPRoB_Qk,
    output logic                    RoBDP_full,
    output logic [RoB_WIDTH-1:0]    RoBDP_index,
    output logic                    RoBDP_Qj_ready,
    output logic                    RoBDP_Qk_ready,
    output logic [31:0]             RoBDP_Vj,
    output logic [31:0]             RoBDP_Vk,
    // common data bus
    input  logic                    CDBRoB_en,
    input  logic [RoB_WIDTH-1:0]    CDBRoB_index,
    input  logic [31:0]             CDBRoB_value,
    input  logic                    CDBRoB_real_jump,
    // commit side
    output logic                    RoBRF_en,
    output logic [RoB_WIDTH-1:0]    RoBRF_RoB_index,
    output logic [EX_REG_WIDTH-1:0] RoBRF_rd,
    output logic [31:0]             RoBRF_value,
    output logic                    RoBRF_pre_judge,
    output logic                    RoBLSB_en,
    output logic [RoB_WIDTH-1:0]    RoBLSB_index,
    output logic                    RoBIF_en,
    output logic [31:0]             RoBIF_pc
);

    localparam int RoB_SIZE = 1 << RoB_WIDTH;

    localparam logic [1:0] TYPE_REG    = 2'd0;
    localparam logic [1:0] TYPE_BRANCH = 2'd1;
    localparam logic [1:0] TYPE_STORE  = 2'd2;
    localparam logic [1:0] TYPE_NOP    = 2'd3;

    localparam logic [RoB_WIDTH-1:0] PTR_ONE    = 1;
    localparam logic [RoB_WIDTH:0]   COUNT_ONE  = 1;
    localparam logic [RoB_WIDTH:0]   COUNT_FULL = {1'b1, {RoB_WIDTH{1'b0}}};

    // Per-entry state: busy is control and is reset; the rest is payload.
    logic [RoB_SIZE-1:0]     busy;
    logic [RoB_SIZE-1:0]     entry_ready;
    logic [RoB_SIZE-1:0]     entry_pred_jump;
    logic [RoB_SIZE-1:0]     entry_real_jump;
    logic [1:0]              entry_type  [RoB_SIZE];
    logic [EX_REG_WIDTH-1:0] entry_rd    [RoB_SIZE];
    logic [31:0]             entry_value [RoB_SIZE];

    logic [RoB_WIDTH-1:0] head;
    logic [RoB_WIDTH-1:0] tail;
    logic [RoB_WIDTH:0]   count;

    logic do_commit;
    logic do_flush;
    logic do_dispatch;
    logic do_write;
    logic commit_reg;
    logic commit_store;
    logic bypass_j;
    logic bypass_k;

    assign RoBDP_full  = (count == COUNT_FULL);
    assign RoBDP_index = tail;
    assign bypass_j    = CDBRoB_en && (CDBRoB_index == DPRoB_Qj);
    assign bypass_k    = CDBRoB_en && (CDBRoB_index == DPRoB_Qk);

    // Decide this cycle's commit, flush, dispatch and writeback actions.
    always_comb begin
        do_commit    = (count != '0) && entry_ready[head];
        commit_reg   = do_commit && (entry_type[head] == TYPE_REG);
        commit_store = do_commit && (entry_type[head] == TYPE_STORE);
        do_flush     = do_commit && (entry_type[head] == TYPE_BRANCH) &&
                       (entry_real_jump[head] != entry_pred_jump[head]);
        // A flush edge drops any dispatch offered in the same cycle.
        do_dispatch  = DPRoB_en && !RoBDP_full && RoBRF_pre_judge && !do_flush;
        do_write     = CDBRoB_en && busy[CDBRoB_index] && RoBRF_pre_judge;
    end

    // Operand-forwarding query: CDB bypass wins over the stored value.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        RoBDP_Vj       = '0;
        RoBDP_Vk       = '0;
        RoBDP_Qj_ready = busy[DPRoB_Qj] && (entry_ready[DPRoB_Qj] || bypass_j);
        RoBDP_Qk_ready = busy[DPRoB_Qk] && (entry_ready[DPRoB_Qk] || bypass_k);
        if (RoBDP_Qj_ready) RoBDP_Vj = bypass_j ? CDBRoB_value : entry_value[DPRoB_Qj];
        if (RoBDP_Qk_ready) RoBDP_Vk = bypass_k ? CDBRoB_value : entry_value[DPRoB_Qk];
    end

    // Pointers, occupancy and the one-cycle commit pulses.
    always_ff @(posedge Sys_clk or negedge Sys_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!Sys_rst) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            RoBRF_en        <= 1'b0;
            RoBRF_RoB_index <= '0;
            RoBRF_rd        <= '0;
            RoBRF_value     <= '0;
            RoBRF_pre_judge <= 1'b1;
            RoBLSB_en       <= 1'b0;
            RoBLSB_index    <= '0;
            RoBIF_en        <= 1'b0;
            RoBIF_pc        <= '0;
        end else if (Sys_rdy) begin
            RoBRF_en        <= commit_reg;
            RoBRF_RoB_index <= commit_reg ? head : '0;
            RoBRF_rd        <= commit_reg ? entry_rd[head] : '0;
            RoBRF_value     <= commit_reg ? entry_value[head] : '0;
            RoBLSB_en       <= commit_store;
            RoBLSB_index    <= commit_store ? head : '0;
            RoBIF_en        <= do_flush;
            RoBIF_pc        <= do_flush ? entry_value[head] : '0;
            RoBRF_pre_judge <= !do_flush;

            if (do_flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (do_commit)   head <= head + PTR_ONE;
                if (do_dispatch) tail <= tail + PTR_ONE;
                case ({do_dispatch, do_commit})
                    2'b10:   count <= count + COUNT_ONE;
                    2'b01:   count <= count - COUNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    // Entry occupancy: set on allocation, cleared on commit or flush.
    always_ff @(posedge Sys_clk or negedge Sys_rst) begin
        if (!Sys_rst) begin
            busy <= '0;
        end else if (Sys_rdy) begin
            if (do_flush) begin
                busy <= '0;
            end else begin
                if (do_commit)   busy[head] <= 1'b0;
                if (do_dispatch) busy[tail] <= 1'b1;
            end
        end
    end

    // Entry payload: written on allocation and on CDB writeback.
    always_ff @(posedge Sys_clk) begin
        // NOTE: payload is not reset; it is only observed through busy, head and count, which are.
        if (Sys_rdy) begin
            if (do_dispatch) begin
                entry_type[tail]      <= DPRoB_type;
                entry_rd[tail]        <= DPRoB_rd;
                entry_pred_jump[tail] <= DPRoB_pred_jump;
                entry_ready[tail]     <= (DPRoB_type == TYPE_NOP);
            end
            if (do_write) begin
                entry_ready[CDBRoB_index]     <= 1'b1;
                entry_value[CDBRoB_index]     <= CDBRoB_value;
                entry_real_jump[CDBRoB_index] <= CDBRoB_real_jump;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: scoreboard of expected commit events plus a query
// vector table and hand-written multi-cycle sequences for reorder_buffer.
module tb_reorder_buffer;

    localparam logic [1:0] T_REG = 2'd0;
    localparam logic [1:0] T_BR  = 2'd1;
    localparam logic [1:0] T_ST  = 2'd2;
    localparam logic [1:0] T_NOP = 2'd3;

    localparam logic [1:0] K_REG = 2'd0;
    localparam logic [1:0] K_ST  = 2'd1;
    localparam logic [1:0] K_IF  = 2'd2;

    // {rf_en, rf_idx, rf_rd, rf_value, lsb_en, lsb_idx, if_en, if_pc, pre_judge}
    localparam logic [81:0] IDLE_VEC = {1'b0, 4'd0, 6'd0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0, 1'b1};

    typedef struct {
        logic [1:0]  kind;
        logic [3:0]  idx;
        logic [5:0]  rd;
        logic [31:0] value;
    } exp_t;

    typedef struct {
        logic [3:0]  qj;
        logic [3:0]  qk;
        logic        cdb_en;
        logic [3:0]  cdb_idx;
        logic [31:0] cdb_val;
        logic        jr;
        logic [31:0] vj;
        logic        kr;
        logic [31:0] vk;
    } qvec_t;

    logic        Sys_clk = 1'b0;
    logic        Sys_rst = 1'b1;
    logic        Sys_rdy = 1'b1;
    logic        DPRoB_en = 1'b0;
    logic [1:0]  DPRoB_type = 2'd0;
    logic [5:0]  DPRoB_rd = 6'd0;
    logic        DPRoB_pred_jump = 1'b0;
    logic [3:0]  DPRoB_Qj = 4'd0;
    logic [3:0]  DPRoB_Qk = 4'd0;
    logic        RoBDP_full;
    logic [3:0]  RoBDP_index;
    logic        RoBDP_Qj_ready;
    logic        RoBDP_Qk_ready;
    logic [31:0] RoBDP_Vj;
    logic [31:0] RoBDP_Vk;
    logic        CDBRoB_en = 1'b0;
    logic [3:0]  CDBRoB_index = 4'd0;
    logic [31:0] CDBRoB_value = 32'd0;
    logic        CDBRoB_real_jump = 1'b0;
    logic        RoBRF_en;
    logic [3:0]  RoBRF_RoB_index;
    logic [5:0]  RoBRF_rd;
    logic [31:0] RoBRF_value;
    logic        RoBRF_pre_judge;
    logic        RoBLSB_en;
    logic [3:0]  RoBLSB_index;
    logic        RoBIF_en;
    logic [31:0] RoBIF_pc;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    bit   rdy_q = 1'b1;
    logic [81:0] act_vec;

    assign act_vec = {RoBRF_en, RoBRF_RoB_index, RoBRF_rd, RoBRF_value,
                      RoBLSB_en, RoBLSB_index, RoBIF_en, RoBIF_pc, RoBRF_pre_judge};

    reorder_buffer #(.RoB_WIDTH(4), .EX_REG_WIDTH(6)) dut (
        .Sys_clk          (Sys_clk),
        .Sys_rst          (Sys_rst),
        .Sys_rdy          (Sys_rdy),
        .DPRoB_en         (DPRoB_en),
        .DPRoB_type       (DPRoB_type),
        .DPRoB_rd         (DPRoB_rd),
        .DPRoB_pred_jump  (DPRoB_pred_jump),
        .DPRoB_Qj         (DPRoB_Qj),
        .DPRoB_Qk         (DPRoB_Qk),
        .RoBDP_full       (RoBDP_full),
        .RoBDP_index      (RoBDP_index),
        .RoBDP_Qj_ready   (RoBDP_Qj_ready),
        .RoBDP_Qk_ready   (RoBDP_Qk_ready),
        .RoBDP_Vj         (RoBDP_Vj),
        .RoBDP_Vk         (RoBDP_Vk),
        .CDBRoB_en        (CDBRoB_en),
        .CDBRoB_index     (CDBRoB_index),
        .CDBRoB_value     (CDBRoB_value),
        .CDBRoB_real_jump (CDBRoB_real_jump),
        .RoBRF_en         (RoBRF_en),
        .RoBRF_RoB_index  (RoBRF_RoB_index),
        .RoBRF_rd         (RoBRF_rd),
        .RoBRF_value      (RoBRF_value),
        .RoBRF_pre_judge  (RoBRF_pre_judge),
        .RoBLSB_en        (RoBLSB_en),
        .RoBLSB_index     (RoBLSB_index),
        .RoBIF_en         (RoBIF_en),
        .RoBIF_pc         (RoBIF_pc)
    );

    always #5 Sys_clk = ~Sys_clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [81:0] exp_vec(input exp_t r);
        case (r.kind)
            K_REG:   return {1'b1, r.idx, r.rd, r.value, 1'b0, 4'd0, 1'b0, 32'd0, 1'b1};
            K_ST:    return {1'b0, 4'd0, 6'd0, 32'd0, 1'b1, r.idx, 1'b0, 32'd0, 1'b1};
            default: return {1'b0, 4'd0, 6'd0, 32'd0, 1'b0, 4'd0, 1'b1, r.value, 1'b0};
        endcase
    endfunction

    // Remember whether the last edge was live so frozen pulses are not recounted.
    always @(posedge Sys_clk) rdy_q <= Sys_rdy;

    // Scoreboard monitor: every commit event must match the oldest expectation.
    always @(negedge Sys_clk) begin
        exp_t r;
        if (Sys_rst && rdy_q && (RoBRF_en || RoBLSB_en || RoBIF_en || !RoBRF_pre_judge)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_commit", act_vec, IDLE_VEC);
            end else begin
                r = exp_q.pop_front();
                check("commit_event", act_vec, exp_vec(r));
            end
        end
    end

    task automatic step();
        @(posedge Sys_clk);
        #1;
    endtask

    task automatic reset_dut();
        Sys_rst   = 1'b0;
        Sys_rdy   = 1'b1;
        DPRoB_en  = 1'b0;
        CDBRoB_en = 1'b0;
        DPRoB_Qj  = 4'd0;
        DPRoB_Qk  = 4'd0;
        exp_q.delete();
        step();
        step();
        Sys_rst = 1'b1;
    endtask

    task automatic dispatch(input logic [1:0] t, input logic [5:0] rd, input logic pred,
                            input logic [3:0] exp_idx, input bit track);
        check("dispatch_index", RoBDP_index, exp_idx);
        DPRoB_en        = 1'b1;
        DPRoB_type      = t;
        DPRoB_rd        = rd;
        DPRoB_pred_jump = pred;
        if (track && t == T_REG) exp_q.push_back('{kind: K_REG, idx: exp_idx, rd: rd, value: 32'd0});
        if (track && t == T_ST)  exp_q.push_back('{kind: K_ST, idx: exp_idx, rd: 6'd0, value: 32'd0});
        step();
        DPRoB_en = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] idx, input logic [31:0] val, input logic real_jump,
                       input bit push_redirect);
        CDBRoB_en        = 1'b1;
        CDBRoB_index     = idx;
        CDBRoB_value     = val;
        CDBRoB_real_jump = real_jump;
        foreach (exp_q[i]) begin
            if (exp_q[i].kind == K_REG && exp_q[i].idx == idx) begin
                exp_q[i].value = val;
                break;
            end
        end
        if (push_redirect) exp_q.push_back('{kind: K_IF, idx: 4'd0, rd: 6'd0, value: val});
        step();
        CDBRoB_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        qvec_t tbl[7];
        tbl[0] = '{qj: 4'd1, qk: 4'd2, cdb_en: 1'b0, cdb_idx: 4'd0, cdb_val: 32'h0,
                   jr: 1'b1, vj: 32'h11, kr: 1'b1, vk: 32'h22};
        tbl[1] = '{qj: 4'd0, qk: 4'd3, cdb_en: 1'b0, cdb_idx: 4'd0, cdb_val: 32'h0,
                   jr: 1'b0, vj: 32'h0, kr: 1'b0, vk: 32'h0};
        tbl[2] = '{qj: 4'd3, qk: 4'd4, cdb_en: 1'b1, cdb_idx: 4'd3, cdb_val: 32'hAB,
                   jr: 1'b1, vj: 32'hAB, kr: 1'b0, vk: 32'h0};
        tbl[3] = '{qj: 4'd5, qk: 4'd3, cdb_en: 1'b1, cdb_idx: 4'd5, cdb_val: 32'h55,
                   jr: 1'b0, vj: 32'h0, kr: 1'b0, vk: 32'h0};
        tbl[4] = '{qj: 4'd2, qk: 4'd2, cdb_en: 1'b1, cdb_idx: 4'd2, cdb_val: 32'h99,
                   jr: 1'b1, vj: 32'h99, kr: 1'b1, vk: 32'h99};
        tbl[5] = '{qj: 4'd4, qk: 4'd1, cdb_en: 1'b1, cdb_idx: 4'd4, cdb_val: 32'h44,
                   jr: 1'b1, vj: 32'h44, kr: 1'b1, vk: 32'h11};
        tbl[6] = '{qj: 4'd0, qk: 4'd4, cdb_en: 1'b1, cdb_idx: 4'd0, cdb_val: 32'h5,
                   jr: 1'b1, vj: 32'h5, kr: 1'b0, vk: 32'h0};

        #2;
        // Reset state and a single REG instruction.
        reset_dut();
        check("reset_outputs", {RoBDP_full, RoBDP_index, act_vec}, {1'b0, 4'd0, IDLE_VEC});
        dispatch(T_REG, 6'd5, 1'b0, 4'd0, 1);
        check("index_after_alloc", RoBDP_index, 4'd1);
        cdb(4'd0, 32'h1234, 1'b0, 0);
        step();
        check("reg_commit", {RoBRF_en, RoBRF_RoB_index, RoBRF_rd, RoBRF_value},
              {1'b1, 4'd0, 6'd5, 32'h1234});
        step();
        check("reg_pulse_one_cycle", RoBRF_en, 1'b0);

        // Out-of-order writeback, in-order commit.
        reset_dut();
        dispatch(T_REG, 6'd10, 1'b0, 4'd0, 1);
        dispatch(T_REG, 6'd11, 1'b0, 4'd1, 1);
        cdb(4'd1, 32'hB1, 1'b0, 0);
        step();
        step();
        check("no_commit_past_head", RoBRF_en, 1'b0);
        cdb(4'd0, 32'hA0, 1'b0, 0);
        step();
        check("inorder_first", {RoBRF_en, RoBRF_RoB_index}, {1'b1, 4'd0});
        step();
        check("inorder_second", {RoBRF_en, RoBRF_RoB_index, RoBRF_value}, {1'b1, 4'd1, 32'hB1});
        step();
        check("inorder_idle", RoBRF_en, 1'b0);

        // Query table against a partially written buffer (head blocked).
        reset_dut();
        for (int i = 0; i < 5; i++) dispatch(T_REG, 6'(i + 1), 1'b0, 4'(i), 1);
        cdb(4'd1, 32'h11, 1'b0, 0);
        cdb(4'd2, 32'h22, 1'b0, 0);
        foreach (tbl[i]) begin
            DPRoB_Qj     = tbl[i].qj;
            DPRoB_Qk     = tbl[i].qk;
            CDBRoB_en    = tbl[i].cdb_en;
            CDBRoB_index = tbl[i].cdb_idx;
            CDBRoB_value = tbl[i].cdb_val;
            #1;
            check($sformatf("query_j_%0d", i), {RoBDP_Qj_ready, RoBDP_Vj}, {tbl[i].jr, tbl[i].vj});
            check($sformatf("query_k_%0d", i), {RoBDP_Qk_ready, RoBDP_Vk}, {tbl[i].kr, tbl[i].vk});
            CDBRoB_en = 1'b0;
        end
        cdb(4'd0, 32'hA, 1'b0, 0);
        cdb(4'd3, 32'h33, 1'b0, 0);
        cdb(4'd4, 32'h44, 1'b0, 0);
        drain();

        // Fill to 16, wrap the tail, same-edge dispatch and commit, overflow ignored.
        reset_dut();
        dispatch(T_REG, 6'd20, 1'b0, 4'd0, 1);
        dispatch(T_REG, 6'd21, 1'b0, 4'd1, 1);
        for (int i = 2; i < 15; i++) dispatch(T_NOP, 6'd0, 1'b0, 4'(i), 0);
        check("not_full_at_15", RoBDP_full, 1'b0);
        cdb(4'd0, 32'hC0, 1'b0, 0);
        dispatch(T_NOP, 6'd0, 1'b0, 4'd15, 0);
        check("simul_keeps_count", {RoBDP_full, RoBDP_index}, {1'b0, 4'd0});
        dispatch(T_NOP, 6'd0, 1'b0, 4'd0, 0);
        check("full_at_16", {RoBDP_full, RoBDP_index}, {1'b1, 4'd1});
        DPRoB_en   = 1'b1;
        DPRoB_type = T_REG;
        step();
        DPRoB_en = 1'b0;
        check("overflow_ignored", {RoBDP_full, RoBDP_index}, {1'b1, 4'd1});
        cdb(4'd1, 32'hC1, 1'b0, 0);
        drain();

        // Mispredicted branch: flush, redirect, dropped dispatches.
        reset_dut();
        dispatch(T_BR, 6'd0, 1'b0, 4'd0, 0);
        dispatch(T_REG, 6'd7, 1'b0, 4'd1, 0);
        cdb(4'd0, 32'h80, 1'b1, 1);
        check("index_before_flush", RoBDP_index, 4'd2);
        DPRoB_en   = 1'b1;
        DPRoB_type = T_REG;
        DPRoB_rd   = 6'd8;
        step();
        check("flush_pulse", {RoBRF_pre_judge, RoBIF_en, RoBIF_pc}, {1'b0, 1'b1, 32'h80});
        check("flush_pointers", {RoBDP_full, RoBDP_index}, {1'b0, 4'd0});
        CDBRoB_en    = 1'b1;
        CDBRoB_index = 4'd1;
        CDBRoB_value = 32'h77;
        step();
        DPRoB_en  = 1'b0;
        CDBRoB_en = 1'b0;
        check("after_flush", {RoBRF_pre_judge, RoBIF_en, RoBDP_index}, {1'b1, 1'b0, 4'd0});
        DPRoB_Qj = 4'd1;
        #1;
        check("flushed_entry_query", {RoBDP_Qj_ready, RoBDP_Vj}, {1'b0, 32'd0});
        dispatch(T_REG, 6'd9, 1'b0, 4'd0, 1);
        cdb(4'd0, 32'h99, 1'b0, 0);
        drain();

        // Correct branch is silent, store releases, Sys_rdy freezes the pulse.
        reset_dut();
        dispatch(T_BR, 6'd0, 1'b1, 4'd0, 0);
        dispatch(T_ST, 6'd0, 1'b0, 4'd1, 1);
        cdb(4'd0, 32'h40, 1'b1, 0);
        cdb(4'd1, 32'h0, 1'b0, 0);
        step();
        check("store_release", {RoBLSB_en, RoBLSB_index, RoBRF_pre_judge, RoBIF_en},
              {1'b1, 4'd1, 1'b1, 1'b0});
        Sys_rdy    = 1'b0;
        DPRoB_en   = 1'b1;
        DPRoB_type = T_NOP;
        step();
        step();
        check("freeze_holds", {RoBLSB_en, RoBLSB_index, RoBDP_index}, {1'b1, 4'd1, 4'd2});
        Sys_rdy  = 1'b1;
        DPRoB_en = 1'b0;
        step();
        check("unfreeze_clears", {RoBLSB_en, RoBDP_index}, {1'b0, 4'd2});
        drain();

        // Asynchronous reset mid-cycle with seven entries and a live pulse.
        reset_dut();
        for (int i = 0; i < 8; i++) dispatch(T_REG, 6'(i + 1), 1'b0, 4'(i), 1);
        cdb(4'd0, 32'h5A, 1'b0, 0);
        step();
        #5;
        Sys_rst  = 1'b0;
        DPRoB_Qj = 4'd2;
        #1;
        check("async_reset_outputs", {RoBDP_full, RoBDP_index, act_vec}, {1'b0, 4'd0, IDLE_VEC});
        check("async_reset_busy", RoBDP_Qj_ready, 1'b0);
        exp_q.delete();
        step();
        Sys_rst = 1'b1;
        dispatch(T_NOP, 6'd0, 1'b0, 4'd0, 0);

        step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
